// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences variable-latency req/ack data-memory accesses beside the MEM stage.
//   clk, reset                  : clock and synchronous active-high reset
//   MemReqM/MemWriteM           : MEM-stage load/store request and store select
//   ALUOutM/WriteDataM          : MEM-stage address and store data
//   MemAck/MemRData             : one-cycle memory completion strobe and read data
//   MemReq/MemWe/MemAddr/MemWData : registered memory request
//   ReadDataM                   : latched load data toward MEM/WB
//   StallF/D/E/M, FlushW        : pipeline hold and MEM/WB bubble
//   BusErr                      : sticky timeout error
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReqM,
  input  logic        MemWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [31:0] ReadDataM,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        StallM,
  output logic        FlushW,
  output logic        BusErr
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              w_stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (MemReqM) begin
          r_state <= ACCESS;
          r_addr  <= ALUOutM;
          r_wdata <= WriteDataM;
          r_we    <= MemWriteM;
          r_req   <= 1'b1;
          r_cnt   <= '0;
        end
        ACCESS: begin
          // ack beats a simultaneous timeout
          if (MemAck) begin
            r_state <= DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            if (!r_we) r_rdata <= MemRData;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_state <= ERR;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: r_state <= IDLE;
        ERR:  r_state <= ERR;
      endcase
    end
  end
  // stall is raised in the request cycle itself so the MEM stage holds before ACCESS begins
  assign w_stall   = (r_state == IDLE && MemReqM) || r_state == ACCESS || r_state == ERR;
  assign StallF    = w_stall;
  assign StallD    = w_stall;
  assign StallE    = w_stall;
  assign StallM    = w_stall;
  assign FlushW    = w_stall;
  assign MemReq    = r_req;
  assign MemWe     = r_we;
  assign MemAddr   = r_addr;
  assign MemWData  = r_wdata;
  assign ReadDataM = r_rdata;
  assign BusErr    = r_err;
endmodule
